cache_mem_arbiter: RTL and testbench

Shares one AXI3/AXI4 master port between the ICache refill path and the DCache refill and write-back paths. It arbitrates line reads between the two caches. It runs independent read and write burst engines. It packs read beats into a full cache line for the requesting cache. It stalls any read whose line matches an outstanding DCache write-back, so a refill never returns stale data.

---
 rtl/cache_mem_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// Shared AXI master for ICache/DCache line refills and DCache write-backs.
// Refills are held off while their line is still in the write-back buffer.
module cache_mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ic_rd_req,
  input  logic [ADDR_W-1:0]        ic_rd_addr,
  output logic                     ic_rd_rdy,
  output logic                     ic_ret_valid,
  output logic [LINE_WORDS*32-1:0] ic_ret_data,
  input  logic                     dc_rd_req,
  input  logic [ADDR_W-1:0]        dc_rd_addr,
  output logic                     dc_rd_rdy,
  output logic                     dc_ret_valid,
  output logic [LINE_WORDS*32-1:0] dc_ret_data,
  input  logic                     dc_wr_req,
  input  logic [ADDR_W-1:0]        dc_wr_addr,
  input  logic [LINE_WORDS*32-1:0] dc_wr_data,
  output logic                     dc_wr_rdy,
  output logic                     arvalid,
  input  logic                     arready,
  output logic [ADDR_W-1:0]        araddr,
  output logic [7:0]               arlen,
  output logic [2:0]               arsize,
  input  logic                     rvalid,
  output logic                     rready,
  input  logic [31:0]              rdata,
  input  logic                     rlast,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [7:0]               awlen,
  output logic [2:0]               awsize,
  output logic                     wvalid,
  input  logic                     wready,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  input  logic                     bvalid,
  output logic                     bready
);

  localparam int L   = LINE_WORDS * 32;
  localparam int OFF = $clog2(LINE_WORDS * 4);
  localparam int CW  = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [7:0]    LEN  = 8'(LINE_WORDS - 1);
  localparam logic [CW-1:0] LAST = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_RET} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wstate_t;

  rstate_t rs, rs_n;
  wstate_t ws, ws_n;

  logic [ADDR_W-1:0] raddr;
  logic              rown_ic;
  logic              last_ic;
  logic [CW-1:0]     beat_cnt;
  logic [L-1:0]      rline;

  logic [ADDR_W-1:0] wb_addr;
  logic [L-1:0]      wb_data;
  logic [CW-1:0]     wcnt;

  logic wb_busy, ic_cand, dc_cand, gnt_ic, gnt_dc;

  // A line still being written back must not be refilled from memory.
  always_comb begin
    wb_busy = (ws != W_IDLE);
    ic_cand = ic_rd_req &&
      !(wb_busy && ic_rd_addr[ADDR_W-1:OFF] == wb_addr[ADDR_W-1:OFF]);
    dc_cand = dc_rd_req &&
      !(wb_busy && dc_rd_addr[ADDR_W-1:OFF] == wb_addr[ADDR_W-1:OFF]);
    gnt_ic  = ic_cand && (!dc_cand || !last_ic);
    gnt_dc  = dc_cand && (!ic_cand || last_ic);
  end

  always_comb begin
    rs_n         = rs;
    ic_rd_rdy    = 1'b0;
    dc_rd_rdy    = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ic_ret_valid = 1'b0;
    dc_ret_valid = 1'b0;
    araddr       = raddr;
    arlen        = LEN;
    arsize       = 3'd2;
    ic_ret_data  = rline;
    dc_ret_data  = rline;
    unique case (rs)
      R_IDLE: begin
        ic_rd_rdy = resetn && gnt_ic;
        dc_rd_rdy = resetn && gnt_dc;
        if (gnt_ic || gnt_dc) rs_n = R_AR;
      end
      R_AR: begin
        arvalid = 1'b1;
        if (arready) rs_n = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rs_n = R_RET;
      end
      R_RET: begin
        ic_ret_valid = rown_ic;
        dc_ret_valid = !rown_ic;
        rs_n         = R_IDLE;
      end
      default: rs_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rs       <= R_IDLE;
      raddr    <= '0;
      rown_ic  <= 1'b0;
      last_ic  <= 1'b1;
      beat_cnt <= '0;
      rline    <= '0;
    end else begin
      rs <= rs_n;
      unique case (rs)
        R_IDLE: begin
          if (gnt_ic || gnt_dc) begin
            raddr   <= gnt_ic ? ic_rd_addr : dc_rd_addr;
            rown_ic <= gnt_ic;
            last_ic <= gnt_ic;
          end
        end
        R_AR: begin
          if (arready) beat_cnt <= '0;
        end
        R_DATA: begin
          if (rvalid) begin
            for (int i = 0; i < LINE_WORDS; i++)
              if (beat_cnt == CW'(i)) rline[32*i +: 32] <= rdata;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ws_n      = ws;
    dc_wr_rdy = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    bready    = 1'b0;
    awaddr    = wb_addr;
    awlen     = LEN;
    awsize    = 3'd2;
    wstrb     = 4'hF;
    wdata     = '0;
    for (int i = 0; i < LINE_WORDS; i++)
      if (wcnt == CW'(i)) wdata = wb_data[32*i +: 32];
    unique case (ws)
      W_IDLE: begin
        dc_wr_rdy = resetn;
        if (dc_wr_req) ws_n = W_AW;
      end
      W_AW: begin
        awvalid = 1'b1;
        if (awready) ws_n = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        wlast  = (wcnt == LAST);
        if (wready && wcnt == LAST) ws_n = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) ws_n = W_IDLE;
      end
      default: ws_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws      <= W_IDLE;
      wb_addr <= '0;
      wb_data <= '0;
      wcnt    <= '0;
    end else begin
      ws <= ws_n;
      if (ws == W_IDLE && dc_wr_req) begin
        wb_addr <= dc_wr_addr;
        wb_data <= dc_wr_data;
        wcnt    <= '0;
      end else if (ws == W_DATA && wready) begin
        wcnt <= wcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with an AXI slave model
// and scoreboards for line returns and write-back beats.
module tb_cache_mem_arbiter;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam int L  = LW * 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ic_rd_req = 1'b0;
  logic [AW-1:0] ic_rd_addr = '0;
  logic ic_rd_rdy, ic_ret_valid;
  logic [L-1:0] ic_ret_data;
  logic dc_rd_req = 1'b0;
  logic [AW-1:0] dc_rd_addr = '0;
  logic dc_rd_rdy, dc_ret_valid;
  logic [L-1:0] dc_ret_data;
  logic dc_wr_req = 1'b0;
  logic [AW-1:0] dc_wr_addr = '0;
  logic [L-1:0] dc_wr_data = '0;
  logic dc_wr_rdy;
  logic arvalid;
  logic arready = 1'b0;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic rvalid = 1'b0;
  logic rready;
  logic [31:0] rdata = '0;
  logic rlast = 1'b0;
  logic awvalid;
  logic awready = 1'b0;
  logic [AW-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize;
  logic wvalid;
  logic wready = 1'b0;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic wlast;
  logic bvalid = 1'b0;
  logic bready;

  cache_mem_arbiter #(.LINE_WORDS(LW), .ADDR_W(AW)) dut (
    .clk(clk), .resetn(resetn),
    .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
    .ic_rd_rdy(ic_rd_rdy), .ic_ret_valid(ic_ret_valid),
    .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_addr(dc_rd_addr),
    .dc_rd_rdy(dc_rd_rdy), .dc_ret_valid(dc_ret_valid),
    .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_addr(dc_wr_addr),
    .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .arlen(arlen), .arsize(arsize),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .awlen(awlen), .awsize(awsize),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  bit salt_en = 1'b0;
  int aw_delay = 0;
  int b_delay = 0;
  bit w_toggle = 1'b0;

  function automatic logic [31:0] gen(input logic [31:0] a, input int b);
    logic [31:0] lo;
    lo = 32'((b + 1) * 17);
    return (salt_en ? {a[19:4], 16'h0} : 32'h0) | lo;
  endfunction

  function automatic logic [L-1:0] line_of(input logic [31:0] a);
    logic [L-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = gen(a, i);
    return l;
  endfunction

  bit r_busy = 1'b0;
  logic [31:0] r_addr = '0;
  int r_beat = 0;
  int aw_cnt = 0;
  int b_cnt = 0;
  bit b_pend = 1'b0;
  bit w_phase = 1'b1;
  bit wb_done = 1'b0;
  logic [31:0] last_araddr = '0;
  logic [7:0] last_arlen = '0;
  logic [2:0] last_arsize = '0;
  logic [31:0] last_awaddr = '0;
  logic [7:0] last_awlen = '0;
  logic [31:0] wexp_q[$];

  // AXI slave: drive on falling edge, commit handshakes on rising edge
  always begin
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs, lst;
    logic [31:0] a_s, e;
    @(negedge clk);
    arready = !r_busy;
    rvalid = r_busy;
    rdata = r_busy ? gen(r_addr, r_beat) : 32'h0;
    rlast = r_busy && (r_beat == LW - 1);
    if (awvalid) begin
      awready = (aw_cnt >= aw_delay);
      aw_cnt++;
    end else begin
      awready = 1'b0;
      aw_cnt = 0;
    end
    wready = w_toggle ? w_phase : 1'b1;
    w_phase = !w_phase;
    bvalid = b_pend && (b_cnt >= b_delay);
    if (b_pend) b_cnt++;
    #1;
    ar_hs = arvalid && arready;
    r_hs = rvalid && rready;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    b_hs = bvalid && bready;
    lst = wlast;
    a_s = araddr;
    if (resetn) begin
      if (ar_hs) begin
        last_araddr = araddr;
        last_arlen = arlen;
        last_arsize = arsize;
      end
      if (aw_hs) begin
        last_awaddr = awaddr;
        last_awlen = awlen;
      end
      if (w_hs) begin
        if (wexp_q.size() == 0) chk("w_extra_beat", 1, 0);
        else begin
          e = wexp_q.pop_front();
          chk("wdata", wdata, e);
          chk("wlast", wlast, wexp_q.size() == 0);
          chk("wstrb", wstrb, 4'hF);
        end
      end
      if (b_pend && !bvalid) chk("bready_hold", bready, 1);
    end
    @(posedge clk);
    if (!resetn) begin
      r_busy = 1'b0;
      b_pend = 1'b0;
      b_cnt = 0;
      aw_cnt = 0;
    end else begin
      if (ar_hs) begin
        r_busy = 1'b1;
        r_addr = a_s;
        r_beat = 0;
      end
      if (r_hs) begin
        if (rlast) r_busy = 1'b0;
        r_beat++;
      end
      if (w_hs && lst) begin
        b_pend = 1'b1;
        b_cnt = 0;
      end
      if (b_hs) begin
        b_pend = 1'b0;
        wb_done = 1'b1;
      end
    end
  end

  typedef struct {
    bit ic;
    logic [L-1:0] line;
  } ret_t;
  ret_t rexp_q[$];
  int ret_cnt = 0;
  int last_ret_cyc = 0;

  always begin
    ret_t e;
    @(negedge clk);
    #1;
    if (resetn && (ic_ret_valid || dc_ret_valid)) begin
      ret_cnt++;
      last_ret_cyc = cyc;
      if (rexp_q.size() == 0) chk("ret_unexpected", 1, 0);
      else begin
        e = rexp_q.pop_front();
        chk("ret_ic_valid", ic_ret_valid, e.ic);
        chk("ret_dc_valid", dc_ret_valid, !e.ic);
        chk("ret_data", e.ic ? ic_ret_data : dc_ret_data, e.line);
      end
    end
  end

  task automatic read_req(input bit ic, input logic [31:0] a,
                          input logic [L-1:0] line, output int gcyc);
    ret_t e;
    e.ic = ic;
    e.line = line;
    @(negedge clk);
    if (ic) begin ic_rd_req = 1'b1; ic_rd_addr = a; end
    else begin dc_rd_req = 1'b1; dc_rd_addr = a; end
    rexp_q.push_back(e);
    gcyc = -1;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (ic ? ic_rd_rdy : dc_rd_rdy) begin
        gcyc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("grant_seen", gcyc >= 0, 1);
    @(negedge clk);
    if (ic) ic_rd_req = 1'b0;
    else dc_rd_req = 1'b0;
  endtask

  task automatic wait_rets(input int n);
    for (int k = 0; k < 200; k++) begin
      if (ret_cnt >= n) break;
      @(negedge clk);
    end
    chk("ret_count", ret_cnt >= n, 1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ctrl"},
        {ic_rd_rdy, dc_rd_rdy, dc_wr_rdy, ic_ret_valid, dc_ret_valid,
         arvalid, rready, awvalid, wvalid, wlast, bready}, 0);
    chk({tag, "_ic_data"}, ic_ret_data, 0);
    chk({tag, "_dc_data"}, dc_ret_data, 0);
    chk({tag, "_addr"}, {araddr, awaddr}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, n;
    logic gs[4];
    bit ic_g, ic_in_stall, dc_g;
    logic [L-1:0] wl;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("idle_wr_rdy", dc_wr_rdy, 1);

    // ICache refill, zero-wait slave, fixed data
    salt_en = 1'b0;
    read_req(1, 32'h1FC0_0040,
             128'h00000044_00000033_00000022_00000011, g);
    wait_rets(1);
    chk("t1_araddr", last_araddr, 32'h1FC0_0040);
    chk("t1_arlen", last_arlen, 3);
    chk("t1_arsize", last_arsize, 2);
    chk("t1_latency", last_ret_cyc - g, 6);

    // Both caches requesting continuously
    salt_en = 1'b1;
    @(negedge clk);
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_4000;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_3000;
    for (int i = 0; i < 4; i++) begin
      ret_t e;
      e.ic = (i % 2 == 1);
      e.line = line_of(e.ic ? 32'h4000 : 32'h3000);
      rexp_q.push_back(e);
    end
    n = 0;
    for (int k = 0; k < 200 && n < 4; k++) begin
      #1;
      if (ic_rd_rdy && dc_rd_rdy) chk("t2_one_rdy", 1, 0);
      if (ic_rd_rdy) begin gs[n] = 1'b1; n++; end
      else if (dc_rd_rdy) begin gs[n] = 1'b0; n++; end
      @(negedge clk);
    end
    ic_rd_req = 1'b0;
    dc_rd_req = 1'b0;
    chk("t2_grants", n, 4);
    chk("t2_order", {gs[0], gs[1], gs[2], gs[3]}, 4'b0101);
    wait_rets(5);

    // Same-line read stalls behind a write-back
    aw_delay = 3;
    b_delay = 0;
    w_toggle = 1'b0;
    wb_done = 1'b0;
    for (int i = 0; i < LW; i++) wl[32*i +: 32] = 32'h1000_0000 + i;
    @(negedge clk);
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_1000; dc_wr_data = wl;
    for (int i = 0; i < LW; i++) wexp_q.push_back(wl[32*i +: 32]);
    #1;
    chk("t3_wr_rdy", dc_wr_rdy, 1);
    @(negedge clk);
    dc_wr_req = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_2000;
    dc_rd_req = 1'b1; dc_rd_addr = 32'h0000_1008;
    begin
      ret_t e;
      e.ic = 1'b1; e.line = line_of(32'h2000); rexp_q.push_back(e);
      e.ic = 1'b0; e.line = line_of(32'h1008); rexp_q.push_back(e);
    end
    ic_g = 1'b0; ic_in_stall = 1'b0; dc_g = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (!wb_done) chk("t3_dc_stall", dc_rd_rdy, 0);
      if (ic_rd_rdy && ic_rd_req) begin
        ic_g = 1'b1;
        ic_in_stall = !wb_done;
      end
      if (dc_rd_rdy) begin dc_g = 1'b1; break; end
      @(negedge clk);
      if (ic_g) ic_rd_req = 1'b0;
    end
    @(negedge clk);
    dc_rd_req = 1'b0;
    ic_rd_req = 1'b0;
    chk("t3_dc_granted", dc_g, 1);
    chk("t3_ic_in_stall", ic_in_stall, 1);
    chk("t3_awaddr", last_awaddr, 32'h0000_1000);
    chk("t3_awlen", last_awlen, 3);
    wait_rets(7);
    chk("t3_araddr", last_araddr, 32'h0000_1008);

    // Write-back with wready toggling and late bvalid
    aw_delay = 0;
    b_delay = 2;
    w_toggle = 1'b1;
    wb_done = 1'b0;
    wl = {32'hD, 32'hC, 32'hB, 32'hA};
    @(negedge clk);
    dc_wr_req = 1'b1; dc_wr_addr = 32'h0000_7000; dc_wr_data = wl;
    for (int i = 0; i < LW; i++) wexp_q.push_back(wl[32*i +: 32]);
    #1;
    chk("t4_wr_rdy", dc_wr_rdy, 1);
    @(negedge clk);
    dc_wr_req = 1'b0;
    for (int k = 0; k < 100 && !wb_done; k++) @(negedge clk);
    chk("t4_wb_done", wb_done, 1);
    chk("t4_beats_left", wexp_q.size(), 0);
    #1;
    chk("t4_wr_rdy_after", dc_wr_rdy, 1);

    // Reset in the middle of a read burst
    w_toggle = 1'b0;
    b_delay = 0;
    @(negedge clk);
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_5000;
    for (int k = 0; k < 60; k++) begin
      #1;
      if (ic_rd_rdy) break;
      @(negedge clk);
    end
    @(negedge clk);
    ic_rd_req = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (r_busy && r_beat == 2 && rready) begin n = 1; break; end
      @(negedge clk);
    end
    chk("t5_beat2_seen", n, 1);
    resetn = 1'b0;
    ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_6000;
    #1;
    chk_reset_outputs("t5_reset");
    repeat (2) @(negedge clk);
    ic_rd_req = 1'b0;
    resetn = 1'b1;
    n = ret_cnt;
    read_req(1, 32'h0000_6000, line_of(32'h6000), g);
    wait_rets(n + 1);
    chk("t5_latency", last_ret_cyc - g, 6);
    chk("t5_araddr", last_araddr, 32'h0000_6000);
    repeat (3) @(negedge clk);
    chk("t5_queue_empty", rexp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
